wavegen_voice_alloc: RTL

//  Polyphonic voice allocator and gate sequencer for the per-voice ADSR envelope generators.

---
 rtl/wavegen_voice_alloc.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/wavegen_voice_alloc.sv
// wavegen_voice_alloc
// Polyphonic voice allocator and gate sequencer feeding the per-voice ADSR envelopes.
// A newly assigned or retriggered voice keeps its gate low until at least one
// sample_strobe has been seen with that gate low. This gives each envelope a clean rising
// edge to retrigger on.
// Build option: define VOICE_STEAL_EN to let a note-on steal the oldest active voice when
// no free or releasing voice exists. When it is undefined, such a note-on is accepted and
// then dropped.
module wavegen_voice_alloc #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned NOTE_W     = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sample_strobe,
    input  logic                           note_on_valid,
    output logic                           note_on_ready,
    input  logic [NOTE_W-1:0]              note_on_num,
    input  logic                           note_off_valid,
    input  logic [NOTE_W-1:0]              note_off_num,
    input  logic [NUM_VOICES-1:0]          voice_idle,
    output logic [NUM_VOICES-1:0]          gate,
    output logic [NUM_VOICES*NOTE_W-1:0]   voice_note,
    output logic                           alloc_valid,
    output logic [$clog2(NUM_VOICES)-1:0]  alloc_voice,
    output logic                           note_dropped
);

    localparam int unsigned VW      = $clog2(NUM_VOICES);
    localparam logic [0:0]  S_IDLE  = 1'b0;
    localparam logic [0:0]  S_WAIT  = 1'b1;
    localparam logic [7:0]  AGE_MAX = 8'hFF;

    logic [0:0]            state_q, state_d;
    logic [VW-1:0]         pend_q, pend_d;
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] low_seen_q, low_seen_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];
    logic [7:0]            age_q  [NUM_VOICES];
    logic [7:0]            age_d  [NUM_VOICES];
    logic                  alloc_valid_q, alloc_valid_d;
    logic [VW-1:0]         alloc_voice_q, alloc_voice_d;
    logic                  dropped_q, dropped_d;

    logic                  retrig_hit, free_hit, rel_hit, tgt_hit;
    logic [VW-1:0]         retrig_idx, free_idx, rel_idx, tgt_idx;
    logic [7:0]            rel_age;
`ifdef VOICE_STEAL_EN
    logic                  act_hit;
    logic [VW-1:0]         act_idx;
    logic [7:0]            act_age;
`endif

    logic                  cancel_hit;

    // Candidate search over registered state; each class keeps its own winner
    always_comb begin
        retrig_hit = 1'b0;
        retrig_idx = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        rel_hit    = 1'b0;
        rel_idx    = '0;
        rel_age    = '0;
`ifdef VOICE_STEAL_EN
        act_hit    = 1'b0;
        act_idx    = '0;
        act_age    = '0;
`endif
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v]) begin
                if (!retrig_hit && (note_q[v] == note_on_num)) begin
                    retrig_hit = 1'b1;
                    retrig_idx = VW'(v);
                end
`ifdef VOICE_STEAL_EN
                // Strict compare keeps the lowest index on an age tie
                if (!act_hit || (age_q[v] > act_age)) begin
                    act_hit = 1'b1;
                    act_idx = VW'(v);
                    act_age = age_q[v];
                end
`endif
            end else if (voice_idle[v]) begin
                if (!free_hit) begin
                    free_hit = 1'b1;
                    free_idx = VW'(v);
                end
            end else begin
                if (!rel_hit || (age_q[v] > rel_age)) begin
                    rel_hit = 1'b1;
                    rel_idx = VW'(v);
                    rel_age = age_q[v];
                end
            end
        end
    end

    // Priority pick of the allocation target
    always_comb begin
        tgt_hit = 1'b1;
        tgt_idx = '0;
        if (retrig_hit) begin
            tgt_idx = retrig_idx;
        end else if (free_hit) begin
            tgt_idx = free_idx;
        end else if (rel_hit) begin
            tgt_idx = rel_idx;
        end
`ifdef VOICE_STEAL_EN
        else if (act_hit) begin
            tgt_idx = act_idx;
        end
`endif
        else begin
            tgt_hit = 1'b0;
        end
    end

    // A note-off naming the pending note cancels the pending allocation
    always_comb begin
        cancel_hit = note_off_valid && (note_off_num == note_q[pend_q]);
    end

    // low_seen tracks "a strobe has passed with this gate low since it last fell"
    always_comb begin
        low_seen_d = low_seen_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (gate_q[v]) begin
                low_seen_d[v] = 1'b0;
            end else if (sample_strobe) begin
                low_seen_d[v] = 1'b1;
            end
        end
    end

    // Allocator FSM, note-off handling, gate, note and age next-state
    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        gate_d        = gate_q;
        note_d        = note_q;
        age_d         = age_q;
        alloc_valid_d = 1'b0;
        alloc_voice_d = alloc_voice_q;
        dropped_d     = 1'b0;

        if (note_off_valid) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (gate_q[v] && (note_q[v] == note_off_num)) begin
                    gate_d[v] = 1'b0;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (note_on_valid) begin
                    if (tgt_hit) begin
                        note_d[tgt_idx] = note_on_num;
                        gate_d[tgt_idx] = 1'b0;
                        pend_d          = tgt_idx;
                        state_d         = S_WAIT;
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cancel_hit) begin
                    state_d = S_IDLE;
                end else if (low_seen_q[pend_q]) begin
                    gate_d[pend_q] = 1'b1;
                    alloc_valid_d  = 1'b1;
                    alloc_voice_d  = pend_q;
                    state_d        = S_IDLE;
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (VW'(v) == pend_q) begin
                            age_d[v] = '0;
                        end else if (age_q[v] != AGE_MAX) begin
                            age_d[v] = age_q[v] + 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pend_q        <= '0;
            gate_q        <= '0;
            low_seen_q    <= '0;
            alloc_valid_q <= 1'b0;
            alloc_voice_q <= '0;
            dropped_q     <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                age_q[v]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            gate_q        <= gate_d;
            low_seen_q    <= low_seen_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_voice_q <= alloc_voice_d;
            dropped_q     <= dropped_d;
            note_q        <= note_d;
            age_q         <= age_d;
        end
    end

    // Flatten per-voice notes onto the output bus
    always_comb begin
        voice_note = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
        end
    end

    assign note_on_ready = (state_q == S_IDLE);
    assign gate          = gate_q;
    assign alloc_valid   = alloc_valid_q;
    assign alloc_voice   = alloc_voice_q;
    assign note_dropped  = dropped_q;

endmodule
